// File: rtl/hilotof_dut_regif_pkg.sv
// Shared definitions for the host-to-DUT register interface.
// Contents:
//   op_t            command opcodes carried in header bits [31:30]
//   state_t         decoder FSM states (also exported on the debug port)
//   A_STATUS/A_USER/A_ID  special read-only addresses
//   HDR_* fields    header bit positions
//   status_word()   packs the STATUS register layout
//   ack_word()      builds the optional write-acknowledge response
package hilotof_dut_regif_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_ECHO  = 2'b11
    } op_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WDATA = 1'b1
    } state_t;

    localparam logic [5:0] A_STATUS = 6'h3D;
    localparam logic [5:0] A_USER   = 6'h3E;
    localparam logic [5:0] A_ID     = 6'h3F;

    localparam int HDR_OP_MSB   = 31;
    localparam int HDR_OP_LSB   = 30;
    localparam int HDR_ADDR_MSB = 29;
    localparam int HDR_ADDR_LSB = 24;

    function automatic logic [31:0] status_word(input logic       overflow,
                                                input logic       unmapped,
                                                input logic [7:0] err_cnt);
        return {overflow, unmapped, 22'h0, err_cnt};
    endfunction

    function automatic logic [31:0] ack_word(input logic [5:0] addr);
        return {2'b01, addr, 24'h0};
    endfunction

endpackage

// File: rtl/hilotof_sync_fifo.sv
// Single-clock first-word-fall-through FIFO for response words.
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   push, push_data        write request; accepted when not full, or when full
//                          and a pop happens on the same edge
//   pop                    read request; ignored while empty
//   pop_data               head word (zero while empty)
//   full, empty, count     occupancy status
// Handshake: a word leaves on an edge where pop is high and empty is low; the
// head word and empty stay stable until that happens.
module hilotof_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // A pop on the same edge frees the slot a full-FIFO push needs.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tells full from empty.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/hilotof_dut_regif.sv
// DUT-side responder for the host-to-DUT 32-bit word stream.
// Decodes command headers from din into register writes, reads and echoes,
// and returns responses through a FIFO on dout.
// Ports:
//   clock, reset_n        clock and asynchronous active-low reset
//   din_valid, din        command/data word; always consumed when valid
//   dout_ready            host accepts dout this cycle
//   dout_valid, dout      response word
//   reg_out               flat register bank, reg k at [32k+31:32k]
//   user_in               live value returned by a read of A_USER
//   dbg_state             decoder FSM state
//   dbg_count             response FIFO occupancy
// dout handshake: dout_valid is high whenever a response is queued and does
// not depend on dout_ready; a word transfers on an edge with dout_valid and
// dout_ready both high; dout and dout_valid hold while dout_ready is low.
module hilotof_dut_regif
    import hilotof_dut_regif_pkg::*;
#(
    parameter int          NUM_REGS   = 8,
    parameter int          RESP_DEPTH = 8,
    parameter int          WRITE_ACK  = 0,
    parameter logic [31:0] ID_VALUE   = 32'h484C_5446
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           din_valid,
    input  logic [31:0]                    din,
    input  logic                           dout_ready,
    output logic                           dout_valid,
    output logic [31:0]                    dout,
    output logic [NUM_REGS*32-1:0]         reg_out,
    input  logic [31:0]                    user_in,
    output state_t                         dbg_state,
    output logic [$clog2(RESP_DEPTH):0]    dbg_count
);

    localparam logic [6:0] NUM_REGS_C = 7'(NUM_REGS);

    state_t                 state_q;
    state_t                 state_d;
    logic [5:0]             addr_q;
    logic [NUM_REGS*32-1:0] regs_q;
    logic                   overflow_q;
    logic                   unmapped_q;
    logic [7:0]             err_cnt_q;

    op_t                    hdr_op;
    logic [5:0]             hdr_addr;
    logic [31:0]            rd_data;
    logic                   rd_unmapped;
    logic                   wr_mapped;

    logic                   latch_addr;
    logic                   wr_en;
    logic                   set_unmapped;
    logic                   push;
    logic [31:0]            push_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;

    assign hdr_op    = op_t'(din[HDR_OP_MSB:HDR_OP_LSB]);
    assign hdr_addr  = din[HDR_ADDR_MSB:HDR_ADDR_LSB];
    assign wr_mapped = ({1'b0, addr_q} < NUM_REGS_C);

    // Read mux, driven from the header address on din.
    always_comb begin
        rd_data     = '0;
        rd_unmapped = 1'b0;
        if ({1'b0, hdr_addr} < NUM_REGS_C) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (hdr_addr == 6'(k)) begin
                    rd_data = regs_q[32*k +: 32];
                end
            end
        end else begin
            case (hdr_addr)
                A_STATUS: rd_data = status_word(overflow_q, unmapped_q, err_cnt_q);
                A_USER:   rd_data = user_in;
                A_ID:     rd_data = ID_VALUE;
                default:  rd_unmapped = 1'b1;
            endcase
        end
    end

    // Decoder FSM: next state and per-word actions.
    always_comb begin
        state_d      = state_q;
        latch_addr   = 1'b0;
        wr_en        = 1'b0;
        set_unmapped = 1'b0;
        push         = 1'b0;
        push_data    = '0;
        case (state_q)
            S_IDLE: begin
                if (din_valid) begin
                    case (hdr_op)
                        OP_WRITE: begin
                            latch_addr = 1'b1;
                            state_d    = S_WDATA;
                        end
                        OP_READ: begin
                            push         = 1'b1;
                            push_data    = rd_data;
                            set_unmapped = rd_unmapped;
                        end
                        OP_ECHO: begin
                            push      = 1'b1;
                            push_data = din;
                        end
                        default: ;
                    endcase
                end
            end
            S_WDATA: begin
                // No timeout: stays here until the data word arrives.
                if (din_valid) begin
                    if (wr_mapped) begin
                        wr_en = 1'b1;
                    end else begin
                        set_unmapped = 1'b1;
                    end
                    if (WRITE_ACK != 0) begin
                        push      = 1'b1;
                        push_data = ack_word(addr_q);
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else if (latch_addr) begin
            addr_q <= hdr_addr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_en && (addr_q == 6'(k))) begin
                    regs_q[32*k +: 32] <= din;
                end
            end
        end
    end

    // A push is lost only when the FIFO is full and nothing leaves this edge.
    assign drop = push && fifo_full && !dout_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
            unmapped_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
            if (set_unmapped) begin
                unmapped_q <= 1'b1;
            end
        end
    end

    hilotof_sync_fifo #(
        .WIDTH (32),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (dout_ready),
        .pop_data  (dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (dbg_count)
    );

    assign dout_valid = !fifo_empty;
    assign reg_out    = regs_q;
    assign dbg_state  = state_q;

endmodule
